// File: rtl/cordic_pkg.sv
// Shared definitions for the vectoring-mode CORDIC (Cartesian -> phase/magnitude).
// Contents: iteration count, binary-angle constants, atan table, datapath
// widths and the FSM state encoding.
// Optional feature macro used by the top level: CORDIC_GAIN_COMP_EN.
package cordic_pkg;

  localparam int ITER     = 10;
  localparam int XY_W     = 14;
  localparam int Z_W      = 13;
  localparam int ANG_PI_2 = 1024;
  localparam int ANG_PI   = 2048;

  // atan(2^-i) in binary-angle units (2048 == pi)
  localparam logic signed [Z_W-1:0] ATAN_TAB [ITER] = '{
    13'sd512, 13'sd302, 13'sd160, 13'sd81, 13'sd41,
    13'sd20,  13'sd10,  13'sd5,   13'sd3,  13'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation, reused for every iteration.
// Ports:
//   x_cur, y_cur, z_cur : current vector and accumulated angle
//   step                : iteration index (0..ITER-1), selects shift and atan
//   x_nxt, y_nxt, z_nxt : vector and angle after this micro-rotation
// The rotation direction drives y toward zero; shifts are arithmetic and
// truncating.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0] x_cur,
  input  logic signed [XY_W-1:0] y_cur,
  input  logic signed [Z_W-1:0]  z_cur,
  input  logic [3:0]             step,
  output logic signed [XY_W-1:0] x_nxt,
  output logic signed [XY_W-1:0] y_nxt,
  output logic signed [Z_W-1:0]  z_nxt
);

  logic signed [XY_W-1:0] x_sh;
  logic signed [XY_W-1:0] y_sh;
  logic signed [Z_W-1:0]  atan_i;

  always_comb begin
    x_sh   = x_cur >>> step;
    y_sh   = y_cur >>> step;
    atan_i = (step < 4'(ITER)) ? ATAN_TAB[step] : '0;
    if (!y_cur[XY_W-1]) begin
      // y >= 0: rotate clockwise
      x_nxt = x_cur + y_sh;
      y_nxt = y_cur - x_sh;
      z_nxt = z_cur + atan_i;
    end else begin
      x_nxt = x_cur - y_sh;
      y_nxt = y_cur + x_sh;
      z_nxt = z_cur - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_atan_mag.sv
// Iterative 10-step vectoring CORDIC: converts a signed 12-bit (x, y) sample
// into a 12-bit binary angle (-2048..2047 == [-pi, pi)) and a 13-bit magnitude.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   x_in, y_in, in_valid  : input sample and its valid
//   in_ready              : high only while idle (registered)
//   angle_out, mag_out    : result, stable while out_valid is high
//   out_valid, out_ready  : result handshake
//   state_dbg             : current FSM state (debug visibility)
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; a valid output is held with stable data until out_ready is seen.
// Macro CORDIC_GAIN_COMP_EN: when defined, adds a COMP cycle that scales the
// magnitude by K = 311/512 to remove the CORDIC gain.
module cordic_vectoring_atan_mag
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] angle_out,
  output logic [12:0] mag_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state_dbg
);

  state_t state, state_nxt;
  logic   accept;

  logic signed [XY_W-1:0] x_r, y_r;
  logic signed [Z_W-1:0]  z_r;
  logic [3:0]             i_cnt;
  logic                   zero_r;

  logic signed [XY_W-1:0] x_ext, y_ext;
  logic signed [XY_W-1:0] x_pre, y_pre;
  logic signed [Z_W-1:0]  z_pre;
  logic signed [XY_W-1:0] x_nxt, y_nxt;
  logic signed [Z_W-1:0]  z_nxt;

  assign state_dbg = state;

  // Quadrant pre-rotation brings the vector into the right half-plane.
  // Sign-extend first so that negating -2048 cannot overflow.
  always_comb begin
    x_ext = {{(XY_W-12){x_in[11]}}, x_in};
    y_ext = {{(XY_W-12){y_in[11]}}, y_in};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[11]) begin
      if (!y_in[11]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = Z_W'(ANG_PI_2);
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -Z_W'(ANG_PI_2);
      end
    end
  end

  cordic_vec_stage u_stage (
    .x_cur (x_r),
    .y_cur (y_r),
    .z_cur (z_r),
    .step  (i_cnt),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

`ifdef CORDIC_GAIN_COMP_EN
  // x * 311/512 via shift-add, truncated
  logic signed [23:0]     x_wide, x_prod;
  logic signed [XY_W-1:0] x_comp;
  assign x_wide = {{(24-XY_W){x_r[XY_W-1]}}, x_r};
  assign x_prod = (x_wide <<< 8) + (x_wide <<< 6) - (x_wide <<< 3) - x_wide;
  assign x_comp = XY_W'(x_prod >>> 9);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ST_ITER;
        end
      end
      ST_ITER: begin
        if (i_cnt == 4'(ITER-1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = ST_COMP;
`else
          state_nxt = ST_HOLD;
`endif
        end
      end
      ST_COMP: state_nxt = ST_HOLD;
      ST_HOLD: begin
        // The first HOLD cycle loads the output registers; release needs
        // out_valid already visible.
        if (out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_cnt     <= '0;
      zero_r    <= 1'b0;
    end else begin
      in_ready <= (state_nxt == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_r    <= x_pre;
            y_r    <= y_pre;
            z_r    <= z_pre;
            i_cnt  <= '0;
            zero_r <= (x_in == 12'd0) && (y_in == 12'd0);
          end
        end
        ST_ITER: begin
          x_r   <= x_nxt;
          y_r   <= y_nxt;
          z_r   <= z_nxt;
          i_cnt <= i_cnt + 4'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: x_r <= x_comp;
`endif
        ST_HOLD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            // z wraps modulo 4096, which is the natural binary-angle wrap
            angle_out <= zero_r ? 12'd0 : z_r[11:0];
            mag_out   <= zero_r ? 13'd0 : x_r[12:0];
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
